// File: rtl/dmem_arb_pkg.sv
// Shared constants, FSM state type and alignment check for the data-memory arbiter.
package dmem_arb_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   // Unsigned widths only exist for loads; any other funct3 is rejected.
   function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] fun3,
                                          input logic we);
      logic mis;
      case (fun3)
         F3_B:    mis = 1'b0;
         F3_BU:   mis = we;
         F3_H:    mis = addr_lo[0];
         F3_HU:   mis = we | addr_lo[0];
         F3_W:    mis = (addr_lo != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant: first valid requester found searching upward from ptr (with wrap).
module dmem_arb_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   grant_idx,
   output logic            grant_any
);

   int unsigned k;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      k         = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = (32'(ptr) + i) % NREQ;
         if (!grant_any && req_valid[k]) begin
            grant_any = 1'b1;
            grant_idx = PW'(k);
         end
      end
      grant[grant_idx] = grant_any;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between NREQ requesters, one access per 3 cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (index 0 first).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = 32,
   parameter int unsigned DW   = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ-1:0]   req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*3-1:0] req_fun3,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [DW-1:0]     rsp_rdata,
   output logic              rsp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [AW-1:0]     mem_addr,
   output logic [2:0]        mem_fun3,
   output logic [6:0]        mem_opcode,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state_q, state_d;
   logic [PW-1:0]   owner_q;
   logic            we_q, err_q;
   logic [AW-1:0]   addr_q;
   logic [2:0]      fun3_q;
   logic [DW-1:0]   wdata_q, rdata_q;

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grant_idx, ptr;
   logic            grant_any, handshake;
   logic            sel_we, sel_mis;
   logic [AW-1:0]   sel_addr;
   logic [2:0]      sel_fun3;
   logic [DW-1:0]   sel_wdata;

   dmem_arb_pick #(
      .NREQ(NREQ),
      .PW  (PW)
   ) u_pick (
      .req_valid(req_valid),
      .ptr      (ptr),
      .grant    (grant),
      .grant_idx(grant_idx),
      .grant_any(grant_any)
   );

   assign handshake = (state_q == IDLE) && grant_any;
   assign req_ready = (state_q == IDLE) ? grant : '0;

   assign sel_we    = req_we[grant_idx];
   assign sel_addr  = req_addr[grant_idx*AW +: AW];
   assign sel_fun3  = req_fun3[grant_idx*3 +: 3];
   assign sel_wdata = req_wdata[grant_idx*DW +: DW];
   assign sel_mis   = is_misaligned(sel_addr[1:0], sel_fun3, sel_we);

`ifdef DMEM_ARB_RR_EN
   logic [PW-1:0] ptr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else if (handshake) begin
         ptr_q <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         fun3_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (handshake) begin
            owner_q <= grant_idx;
            we_q    <= sel_we;
            err_q   <= sel_mis;
            addr_q  <= sel_addr;
            fun3_q  <= sel_fun3;
            wdata_q <= sel_wdata;
            rdata_q <= '0;
         end else if (state_q == ACCESS && !we_q) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_fun3   = '0;
      mem_opcode = '0;
      mem_wdata  = '0;
      rsp_valid  = '0;
      rsp_rdata  = '0;
      rsp_err    = 1'b0;
      case (state_q)
         IDLE: begin
            // Misaligned requests skip the memory and answer straight away.
            if (handshake) state_d = sel_mis ? RESP : ACCESS;
         end
         ACCESS: begin
            state_d    = RESP;
            mem_read   = !we_q;
            mem_write  = we_q;
            mem_addr   = addr_q;
            mem_fun3   = fun3_q;
            mem_opcode = we_q ? OP_STORE : OP_LOAD;
            mem_wdata  = wdata_q;
         end
         RESP: begin
            state_d            = IDLE;
            rsp_valid[owner_q] = 1'b1;
            rsp_rdata          = rdata_q;
            rsp_err            = err_q;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
